// File: rtl/stream_mux_n.sv
// ============================================================================
// stream_mux_n: N-input registered stream mux, external select or round-robin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SELW  = 3,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SELW:0]   C_N    = (SELW+1)'(N);
  localparam logic [SELW-1:0] C_LAST = SELW'(N - 1);

  logic [WIDTH-1:0] w_chan [N];
  logic [SELW-1:0]  w_grant;
  logic             w_granted;
  logic             w_load;
  logic             w_xfer;

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_src;
  logic             r_valid;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign w_chan[i] = in_data[i*WIDTH +: WIDTH];
  end

  if (MODE == 0) begin : g_ext
    assign w_grant   = sel;
    assign w_granted = ({1'b0, sel} < C_N);
  end else begin : g_rr
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_rr;
    logic            w_found;
    logic            w_unused_sel;

    assign w_unused_sel = ^sel;

    // Scan starts at r_ptr and wraps, so the channel after the last winner has priority.
    always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_rr    = '0;
      for (int k = 0; k < N; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!w_found && in_valid[idx[SELW-1:0]]) begin
          w_found = 1'b1;
          w_rr    = idx[SELW-1:0];
        end
      end
    end

    assign w_grant   = w_rr;
    assign w_granted = w_found;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_ptr <= '0;
      end else if (w_xfer) begin
        r_ptr <= (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
      end
    end
  end

  assign w_load = ~r_valid | out_ready;
  assign w_xfer = w_load & w_granted & ~rst & in_valid[w_grant];

  always_comb begin
    in_ready = '0;
    if (w_load && w_granted && !rst) in_ready[w_grant] = 1'b1;
  end

  // Load with no transfer empties the register but keeps the last data/src visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_data  <= w_chan[w_grant];
        r_src   <= w_grant;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_n.sv
// ============================================================================
// tb_stream_mux_n: vector-table bench for stream_mux_n in both select modes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   sel;
  logic [255:0] in_data;
  logic [7:0]   in_valid;
  logic         out_ready;
  logic [31:0]  chan [8];

  logic [7:0]   rdy0, rdy1;
  logic [31:0]  dat0, dat1;
  logic [2:0]   src0, src1;
  logic         ov0, ov1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = chan[i];
  end

  stream_mux_n #(.WIDTH(32), .N(8), .SELW(3), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .out_data(dat0), .out_src(src0), .out_valid(ov0),
    .out_ready(out_ready)
  );

  stream_mux_n #(.WIDTH(32), .N(8), .SELW(3), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(dat1), .out_src(src1), .out_valid(ov1),
    .out_ready(out_ready)
  );

  typedef struct {
    int          m;
    logic        rst;
    logic [2:0]  sel;
    logic [7:0]  valid;
    logic        ordy;
    logic [7:0]  erdy;
    logic        eov;
    logic [2:0]  esrc;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int m, logic r, logic [2:0] s, logic [7:0] v, logic o,
                              logic [7:0] er, logic eov, logic [2:0] es, logic [31:0] ed);
    vec_t x;
    x.m = m; x.rst = r; x.sel = s; x.valid = v; x.ordy = o;
    x.erdy = er; x.eov = eov; x.esrc = es; x.edata = ed;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; in_ready is checked before the rising edge, outputs after.
  task automatic apply(input vec_t v, input string tag);
    logic [7:0] r;
    @(negedge clk);
    rst = v.rst; sel = v.sel; in_valid = v.valid; out_ready = v.ordy;
    #1;
    r = (v.m == 1) ? rdy1 : rdy0;
    chk({tag, ".in_ready"}, 32'(r), 32'(v.erdy));
    @(posedge clk);
    #1;
    if (v.m == 1) begin
      chk({tag, ".out_valid"}, 32'(ov1), 32'(v.eov));
      chk({tag, ".out_src"},   32'(src1), 32'(v.esrc));
      chk({tag, ".out_data"},  dat1, v.edata);
    end else begin
      chk({tag, ".out_valid"}, 32'(ov0), 32'(v.eov));
      chk({tag, ".out_src"},   32'(src0), 32'(v.esrc));
      chk({tag, ".out_data"},  dat0, v.edata);
    end
  endtask

  initial begin
    rst = 1'b1; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) chan[i] = 32'hA000_0000 + 32'(i);

    // MODE 0: reset with all inputs valid, select sweep, select of an idle channel
    tbl.push_back(mk(0, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 32'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 3'(i), 8'hFF, 1, 8'(1 << i), 1, 3'(i), 32'hA000_0000 + 32'(i)));
    tbl.push_back(mk(0, 0, 5, 8'h00, 1, 8'h20, 0, 7, 32'hA000_0007));

    // MODE 1: reset, two fair rounds, sparse wrap, drain
    tbl.push_back(mk(1, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 32'h0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 8'(1 << (i % 8)), 1, 3'(i % 8),
                       32'hA000_0000 + 32'(i % 8)));
    tbl.push_back(mk(1, 0, 0, 8'h85, 1, 8'h01, 1, 0, 32'hA000_0000));
    tbl.push_back(mk(1, 0, 0, 8'h85, 1, 8'h04, 1, 2, 32'hA000_0002));
    tbl.push_back(mk(1, 0, 0, 8'h85, 1, 8'h80, 1, 7, 32'hA000_0007));
    tbl.push_back(mk(1, 0, 0, 8'h85, 1, 8'h01, 1, 0, 32'hA000_0000));
    tbl.push_back(mk(1, 0, 0, 8'h85, 1, 8'h04, 1, 2, 32'hA000_0002));
    tbl.push_back(mk(1, 0, 0, 8'h85, 1, 8'h80, 1, 7, 32'hA000_0007));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 8'h00, 0, 7, 32'hA000_0007));
    // MODE 1 backpressure: empty register loads, full register stalls, then drains
    tbl.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h01, 1, 0, 32'hA000_0000));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h00, 1, 0, 32'hA000_0000));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h02, 1, 1, 32'hA000_0001));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h04, 1, 2, 32'hA000_0002));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h08, 1, 3, 32'hA000_0003));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h10, 1, 4, 32'hA000_0004));
    // Reset with pointer at 5 and a beat pending; arbitration restarts at channel 0
    tbl.push_back(mk(1, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h01, 1, 0, 32'hA000_0000));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("vec%0d", k));

    // MODE 0 stall: held beat must survive a source change and leave exactly once
    apply(mk(0, 1, 3, 8'hFF, 0, 8'h00, 0, 0, 32'h0), "stall.rst");
    chan[3] = 32'hDEAD_BEEF;
    apply(mk(0, 0, 3, 8'hFF, 0, 8'h08, 1, 3, 32'hDEAD_BEEF), "stall.load");
    chan[3] = 32'hC0FF_EE03;
    for (int k = 0; k < 4; k++)
      apply(mk(0, 0, 3, 8'hFF, 0, 8'h00, 1, 3, 32'hDEAD_BEEF), $sformatf("stall.hold%0d", k));
    apply(mk(0, 0, 3, 8'hFF, 1, 8'h08, 1, 3, 32'hC0FF_EE03), "stall.release");
    apply(mk(0, 0, 3, 8'h00, 1, 8'h08, 0, 3, 32'hC0FF_EE03), "stall.drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
